// File: rtl/load_store_unit.sv
// Load/store unit: one memory op at a time over a simple req/ack bus.
// Ports: clk, rst_n (sync, active-low); issue side start, mem_write,
//   mem_width, mem_unsigned, addr, wdata, rd; result side busy, done,
//   rdata, rd_out, fault; bus side bus_req, bus_we, bus_addr,
//   bus_wdata, bus_strb, bus_ack, bus_rdata.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned or reserved-width
//   accesses with fault instead of silently aligning them.
module load_store_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        mem_write,
  input  logic [1:0]  mem_width,
  input  logic        mem_unsigned,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [4:0]  rd,
  output logic        busy,
  output logic        done,
  output logic [31:0] rdata,
  output logic [4:0]  rd_out,
  output logic        fault,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_strb,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_DONE
  } state_t;

  state_t      state;
  logic        we_q;
  logic        uns_q;
  logic [1:0]  width_q;
  logic [1:0]  off_q;
  logic [4:0]  rd_q;

  logic [1:0]  width_n;
  logic [1:0]  off_n;
  logic        misal;
  logic [3:0]  strb_n;
  logic [31:0] wdata_n;
  logic [31:0] shifted;
  logic [31:0] load_ext;

  // Decode the incoming request; only meaningful in IDLE.
  always_comb begin
    width_n = mem_width;
    misal   = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
    misal = (mem_width == 2'b11)
          | ((mem_width == 2'b01) & addr[0])
          | ((mem_width == 2'b10) & (addr[1:0] != 2'b00));
`else
    if (mem_width == 2'b11) width_n = 2'b10;
`endif
    case (width_n)
      2'b00: begin
        off_n   = addr[1:0];
        strb_n  = 4'b0001 << addr[1:0];
        wdata_n = {4{wdata[7:0]}};
      end
      2'b01: begin
        // low address bit is dropped: halves sit on lanes 0-1 or 2-3
        off_n   = {addr[1], 1'b0};
        strb_n  = 4'b0011 << {addr[1], 1'b0};
        wdata_n = {2{wdata[15:0]}};
      end
      default: begin
        off_n   = 2'b00;
        strb_n  = 4'b1111;
        wdata_n = wdata;
      end
    endcase
  end

  // Align and extend returned read data using the captured request.
  always_comb begin
    shifted = bus_rdata >> {off_q, 3'b000};
    case (width_q)
      2'b00: begin
        if (uns_q) load_ext = {24'd0, shifted[7:0]};
        else       load_ext = {{24{shifted[7]}}, shifted[7:0]};
      end
      2'b01: begin
        if (uns_q) load_ext = {16'd0, shifted[15:0]};
        else       load_ext = {{16{shifted[15]}}, shifted[15:0]};
      end
      default: load_ext = shifted;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      we_q      <= 1'b0;
      uns_q     <= 1'b0;
      width_q   <= 2'b00;
      off_q     <= 2'b00;
      rd_q      <= 5'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
      fault     <= 1'b0;
      rdata     <= 32'd0;
      rd_out    <= 5'd0;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= 32'd0;
      bus_wdata <= 32'd0;
      bus_strb  <= 4'b0000;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            we_q    <= mem_write;
            uns_q   <= mem_unsigned;
            width_q <= width_n;
            off_q   <= off_n;
            rd_q    <= rd;
            busy    <= 1'b1;
            if (misal) begin
              // trapped access never touches the bus
              state  <= S_DONE;
              done   <= 1'b1;
              fault  <= 1'b1;
              rdata  <= 32'd0;
              rd_out <= 5'd0;
            end else begin
              state     <= S_REQ;
              bus_req   <= 1'b1;
              bus_we    <= mem_write;
              bus_addr  <= {addr[31:2], 2'b00};
              bus_wdata <= wdata_n;
              bus_strb  <= strb_n;
            end
          end
        end
        S_REQ: begin
          if (bus_ack) begin
            state   <= S_DONE;
            bus_req <= 1'b0;
            done    <= 1'b1;
            rdata   <= we_q ? 32'd0 : load_ext;
            rd_out  <= we_q ? 5'd0 : rd_q;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          fault <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have ports: clk  input  1  rising-edge clock.
REQ-002 SHALL have: rst_n  input  1  reset, synchronous, active-low.
REQ-003 SHALL have: start  input  1  issue a memory op; sampled only when busy=0.
REQ-004 SHALL have: mem_write  input  1  1=store, 0=load.
REQ-005 SHALL have: mem_width  input  2  00 byte, 01 half, 10 word, 11 reserved.
REQ-006 SHALL have: mem_unsigned  input  1  load zero-extend (1) or sign-extend (0).
REQ-007 SHALL have: addr  input  32  byte address; wdata  input  32  store data in bits [width-1:0]; rd  input  5  load destination.
REQ-008 SHALL have: busy  output  1; done  output  1  one-cycle completion pulse; rdata  output  32  extended load result; rd_out  output  5  writeback register; fault  output  1  access fault.
REQ-009 SHALL have bus ports: bus_req  output  1; bus_we  output  1; bus_addr  output  32; bus_wdata  output  32; bus_strb  output  4; bus_ack  input  1; bus_rdata  input  32.

Function
REQ-010 SHALL implement FSM IDLE -> REQ -> DONE -> IDLE; busy=1 in REQ and DONE.
REQ-011 In IDLE with start=1, SHALL capture mem_write, mem_width, mem_unsigned, addr, wdata and rd, then enter REQ next edge; start when busy=1 SHALL be ignored.
REQ-012 In REQ, SHALL hold bus_req=1 and all bus outputs stable until a cycle with bus_ack=1, then enter DONE.
REQ-013 bus_addr SHALL be {addr[31:2],2'b00}; bus_we SHALL equal captured mem_write.
REQ-014 bus_strb SHALL be: byte 4'b0001<<addr[1:0]; half 4'b0011<<addr[1:0]; word 4'b1111; loads SHALL drive the same strobes.
REQ-015 bus_wdata SHALL replicate the byte across all 4 lanes (byte), the halfword across both halves (half), or pass wdata (word).
REQ-016 On the bus_ack cycle of a load, SHALL capture bus_rdata shifted right by 8*addr[1:0], truncated to width, sign- or zero-extended per mem_unsigned, into rdata.
REQ-017 In DONE, done=1 for exactly one cycle; rd_out = captured rd for loads and 0 for stores; rdata for stores SHALL be 0.
REQ-018 rdata and rd_out SHALL hold their value after DONE until the next done pulse.
REQ-019 Minimum latency: start at cycle N, bus_req at N+1, done at N+2 if bus_ack is high at N+1; each wait cycle adds one.
REQ-020 A new start SHALL be accepted on the cycle after done (back-to-back throughput one op per 3 cycles minimum).
REQ-021 bus_ack outside REQ SHALL be ignored.

Reset
REQ-022 When rst_n=0 at a clock edge, SHALL enter IDLE and force busy, done, fault, bus_req, bus_we to 0, bus_strb to 0, and rdata, rd_out, bus_addr, bus_wdata to 0.
REQ-023 Reset asserted during REQ SHALL drop bus_req at that edge with no done pulse; a late bus_ack SHALL be ignored.

Configuration
REQ-024 Macro LSU_MISALIGN_TRAP_EN SHALL select misalignment handling.
REQ-025 With LSU_MISALIGN_TRAP_EN defined: half with addr[0]=1, word with addr[1:0]!=0, or mem_width=11 SHALL skip REQ (no bus_req), go IDLE -> DONE, assert done and fault together for one cycle, rd_out=0, rdata=0.
REQ-026 Without LSU_MISALIGN_TRAP_EN: fault SHALL be tied 0; mem_width=11 SHALL be treated as word; misaligned half SHALL use addr[1] only (addr[0] treated as 0) and misaligned word SHALL use addr[1:0]=00.

Verification
REQ-027 Load byte signed: addr=0x1003, bus_rdata=0x80FF_1234, ack at first REQ cycle -> bus_strb=1000, bus_addr=0x1000, done at N+2, rdata=0xFFFF_FF80, rd_out=rd.
REQ-028 Store half: addr=0x2002, wdata=0x0000_ABCD, ack after 3 wait cycles -> bus_we=1, bus_strb=1100, bus_wdata=0xABCD_ABCD stable across waits, done at N+5, rd_out=0.
REQ-029 Load half unsigned: addr=0x0002, bus_rdata=0xF00D_0000 -> rdata=0x0000_F00D.
REQ-030 start pulsed while busy and bus_ack pulsed in IDLE -> both ignored; exactly one done per accepted start.
REQ-031 Reset mid-REQ then bus_ack -> bus_req=0 after reset edge, no done, outputs at reset values.
REQ-032 Word load addr=0x0006: with macro -> done=1, fault=1, no bus_req; without macro -> bus_addr=0x0004, strb=1111, fault=0.
